// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ===========================================================================
// pipelined_cla_adder - WIDTH-bit CLA add/sub, one BLOCK-bit slice per stage
// Rev 1.0
// ===========================================================================
module pipelined_cla_adder #(
   parameter int WIDTH = 64,
   parameter int BLOCK = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic [3:0]       status
);

   localparam int STAGES  = WIDTH / BLOCK;
   localparam int NGROUPS = BLOCK / 4;

   function automatic logic [BLOCK:0] cla_slice(input logic [BLOCK-1:0] a,
                                                input logic [BLOCK-1:0] b,
                                                input logic             cin);
      logic [BLOCK-1:0]   g, p, c;
      logic [NGROUPS-1:0] gg, gp;
      logic [NGROUPS:0]   gc;
      logic               t;
      g = a & b;
      p = a ^ b;
      for (int i = 0; i < NGROUPS; i++) begin
         gg[i] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (p[4*i+3] & p[4*i+2] & g[4*i+1])
               | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
         gp[i] = &p[4*i +: 4];
      end
      // Group carries are flat sums of products: no ripple from group to group.
      gc[0] = cin;
      for (int j = 1; j <= NGROUPS; j++) begin
         gc[j] = 1'b0;
         for (int i = 0; i < j; i++) begin
            t = gg[i];
            for (int m = i + 1; m < j; m++) t = t & gp[m];
            gc[j] = gc[j] | t;
         end
         t = cin;
         for (int m = 0; m < j; m++) t = t & gp[m];
         gc[j] = gc[j] | t;
      end
      for (int i = 0; i < NGROUPS; i++) begin
         c[4*i]   = gc[i];
         c[4*i+1] = g[4*i] | (p[4*i] & gc[i]);
         c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & gc[i]);
         c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1]) | (p[4*i+2] & p[4*i+1] & g[4*i])
                  | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
      end
      return {gc[NGROUPS], p ^ c};
   endfunction

   logic w_stall;
   logic w_adv;

   assign w_stall  = out_valid & ~out_ready;
   assign w_adv    = ~w_stall;
   assign in_ready = ~reset & ~w_stall;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int REM = WIDTH - k * BLOCK;
      localparam int LO  = (k + 1) * BLOCK;

      logic [REM-1:0] w_a;
      logic [REM-1:0] w_b;
      logic           w_c;
      logic           w_v;
      logic [BLOCK:0] w_res;
      logic [LO-1:0]  s_d;
      logic [LO-1:0]  s_q;
      logic           c_q;
      logic           v_q;

      if (k == 0) begin : g_first
         assign w_a = A;
         assign w_b = sub ? ~B : B;
         assign w_c = sub | Cin;
         assign w_v = in_valid & in_ready;
         assign s_d = w_res[BLOCK-1:0];
      end else begin : g_next
         assign w_a = g_stage[k-1].g_fwd.a_q;
         assign w_b = g_stage[k-1].g_fwd.b_q;
         assign w_c = g_stage[k-1].c_q;
         assign w_v = g_stage[k-1].v_q;
         assign s_d = {w_res[BLOCK-1:0], g_stage[k-1].s_q};
      end

      assign w_res = cla_slice(w_a[BLOCK-1:0], w_b[BLOCK-1:0], w_c);

      // Data only loads for valid ops, so the outputs hold across bubbles.
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (w_adv) begin
            v_q <= w_v;
            if (w_v) begin
               c_q <= w_res[BLOCK];
               s_q <= s_d;
            end
         end
      end

      if (k < STAGES - 1) begin : g_fwd
         logic [REM-BLOCK-1:0] a_q;
         logic [REM-BLOCK-1:0] b_q;

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               a_q <= '0;
               b_q <= '0;
            end else if (w_adv && w_v) begin
               a_q <= w_a[REM-1:BLOCK];
               b_q <= w_b[REM-1:BLOCK];
            end
         end
      end else begin : g_flags
         logic [3:0] status_d;
         logic [3:0] status_q;

         assign status_d = {s_d[WIDTH-1],
                            (s_d == '0),
                            w_res[BLOCK],
                            (w_a[REM-1] == w_b[REM-1]) && (s_d[WIDTH-1] != w_a[REM-1])};

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               status_q <= 4'b0000;
            end else if (w_adv && w_v) begin
               status_q <= status_d;
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].v_q;
   assign Sum       = g_stage[STAGES-1].s_q;
   assign Cout      = g_stage[STAGES-1].c_q;
   assign status    = g_stage[STAGES-1].g_flags.status_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// ===========================================================================
// tb_pipelined_cla_adder - directed table, streaming, stall, reset and random checks
// Rev 1.0
// ===========================================================================
module tb_pipelined_cla_adder;

   localparam int NDUT = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass   = 0;
   int n_checks = 0;

   int dut_w [NDUT] = '{64, 32, 64};
   int dut_st[NDUT] = '{4, 4, 16};

   logic        inv  [NDUT];
   logic        outr [NDUT];
   logic        cin_d[NDUT];
   logic        sub_d[NDUT];
   logic [63:0] a_d  [NDUT];
   logic [63:0] b_d  [NDUT];
   logic        inrdy[NDUT];
   logic        outv [NDUT];
   logic        cout_m[NDUT];
   logic [63:0] sum_m[NDUT];
   logic [3:0]  st_m [NDUT];
   logic [31:0] sum32;

   pipelined_cla_adder #(.WIDTH(64), .BLOCK(16)) u_dut (
      .clock(clk), .reset(rst), .in_valid(inv[0]), .in_ready(inrdy[0]),
      .A(a_d[0]), .B(b_d[0]), .Cin(cin_d[0]), .sub(sub_d[0]),
      .out_valid(outv[0]), .out_ready(outr[0]), .Sum(sum_m[0]),
      .Cout(cout_m[0]), .status(st_m[0]));

   pipelined_cla_adder #(.WIDTH(32), .BLOCK(8)) u_dut_w32 (
      .clock(clk), .reset(rst), .in_valid(inv[1]), .in_ready(inrdy[1]),
      .A(a_d[1][31:0]), .B(b_d[1][31:0]), .Cin(cin_d[1]), .sub(sub_d[1]),
      .out_valid(outv[1]), .out_ready(outr[1]), .Sum(sum32),
      .Cout(cout_m[1]), .status(st_m[1]));
   assign sum_m[1] = {32'h0, sum32};

   pipelined_cla_adder #(.WIDTH(64), .BLOCK(4)) u_dut_b4 (
      .clock(clk), .reset(rst), .in_valid(inv[2]), .in_ready(inrdy[2]),
      .A(a_d[2]), .B(b_d[2]), .Cin(cin_d[2]), .sub(sub_d[2]),
      .out_valid(outv[2]), .out_ready(outr[2]), .Sum(sum_m[2]),
      .Cout(cout_m[2]), .status(st_m[2]));

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        cin;
      logic        sub;
      logic [63:0] sum;
      logic        cout;
      logic [3:0]  st;
   } vec_t;

   typedef struct {
      logic [63:0] s;
      logic        c;
      logic [3:0]  f;
      int          t;
   } exp_t;

   vec_t vt[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference: plain (w+1)-bit arithmetic and the NZCV definitions.
   function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic s_op,
                                 output logic [63:0] s, output logic c, output logic [3:0] fl);
      logic [63:0] mask;
      logic [63:0] be;
      logic [64:0] full;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      be   = s_op ? (~b & mask) : (b & mask);
      full = {1'b0, a & mask} + {1'b0, be} + 65'(s_op ? 1'b1 : cin);
      s    = full[63:0] & mask;
      c    = full[w];
      fl   = {s[w-1], s == 64'd0, c, (a[w-1] == be[w-1]) && (s[w-1] != a[w-1])};
   endfunction

   function automatic logic [63:0] pick(input int w);
      logic [63:0] mask;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      case ($urandom_range(7))
         0:       return 64'd0;
         1:       return mask;
         2:       return 64'd1 << (w - 1);
         default: return {$urandom, $urandom} & mask;
      endcase
   endfunction

   task automatic run_vec(input string nm, input vec_t v);
      int          lat;
      logic [63:0] held;
      @(negedge clk);
      a_d[0] = v.a; b_d[0] = v.b; cin_d[0] = v.cin; sub_d[0] = v.sub; inv[0] = 1'b1;
      @(negedge clk);
      inv[0] = 1'b0;
      lat = 1;
      while (!outv[0] && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, "_latency"}, 64'(lat), 64'd4);
      chk({nm, "_sum"}, sum_m[0], v.sum);
      chk({nm, "_cout"}, 64'(cout_m[0]), 64'(v.cout));
      chk({nm, "_status"}, 64'(st_m[0]), 64'(v.st));
      held = sum_m[0];
      @(negedge clk);
      chk({nm, "_bubble_valid"}, 64'(outv[0]), 64'd0);
      chk({nm, "_hold_sum"}, sum_m[0], held);
   endtask

   task automatic streaming_test();
      @(negedge clk);
      a_d[0] = 64'd0; b_d[0] = 64'd0; cin_d[0] = 1'b1; sub_d[0] = 1'b0; inv[0] = 1'b1;
      for (int n = 1; n <= 21; n++) begin
         @(negedge clk);
         chk($sformatf("stream_valid_c%0d", n), 64'(outv[0]), 64'((n >= 4 && n <= 19) ? 1 : 0));
         if (n >= 4 && n <= 19) chk($sformatf("stream_sum_c%0d", n), sum_m[0], 64'(n - 3));
         if (n < 16) a_d[0] = 64'(n);
         else        inv[0] = 1'b0;
      end
   endtask

   task automatic backpressure_test();
      int          sent = 0;
      int          got = 0;
      int          first_t = -1;
      int          last_t = -1;
      logic        prev_stall = 1'b0;
      logic [63:0] prev_sum = '0;
      for (int t = 1; t <= 40 && got < 10; t++) begin
         @(negedge clk);
         outr[0] = !(t >= 8 && t <= 10);
         if (sent < 10) begin
            inv[0] = 1'b1; a_d[0] = 64'(100 + sent); b_d[0] = '0; cin_d[0] = 1'b0; sub_d[0] = 1'b0;
         end else begin
            inv[0] = 1'b0;
         end
         #1;
         if (!outr[0]) begin
            chk("bp_valid_held", 64'(outv[0]), 64'd1);
            chk("bp_in_ready", 64'(inrdy[0]), 64'd0);
            if (prev_stall) chk("bp_sum_stable", sum_m[0], prev_sum);
         end
         if (outv[0] && outr[0]) begin
            chk("bp_order", sum_m[0], 64'(100 + got));
            got++;
            if (first_t < 0) first_t = t;
            last_t = t;
         end
         if (inv[0] && inrdy[0]) sent++;
         prev_stall = !outr[0];
         prev_sum   = sum_m[0];
      end
      inv[0] = 1'b0; outr[0] = 1'b1;
      chk("bp_count", 64'(got), 64'd10);
      chk("bp_no_gaps", 64'(last_t - first_t + 1), 64'd13);
   endtask

   task automatic reset_test();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         inv[0] = 1'b1; a_d[0] = 64'(i + 1); b_d[0] = '0; cin_d[0] = 1'b0; sub_d[0] = 1'b0;
      end
      @(negedge clk);
      inv[0] = 1'b0;
      chk("rst_pre_valid", 64'(outv[0]), 64'd1);
      chk("rst_pre_sum", sum_m[0], 64'd2);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_valid", 64'(outv[0]), 64'd0);
      chk("rst_async_sum", sum_m[0], 64'd0);
      chk("rst_async_cout", 64'(cout_m[0]), 64'd0);
      chk("rst_async_status", 64'(st_m[0]), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("rst_no_stale", 64'(outv[0]), 64'd0);
      end
      run_vec("rst_new_op", vt[5]);
   endtask

   task automatic run_stream(input int idx, input int nops, input int vpct, input int rpct,
                             input bit chk_lat);
      exp_t        q[$];
      exp_t        e;
      int          sent = 0;
      int          got = 0;
      int          steps = 0;
      int          w;
      logic [63:0] ms;
      logic        mc;
      logic [3:0]  mf;
      w = dut_w[idx];
      while ((sent < nops || got < nops) && steps < 20 * nops + 100) begin
         @(negedge clk);
         steps++;
         outr[idx] = ($urandom_range(99) < rpct);
         if (sent < nops && $urandom_range(99) < vpct) begin
            inv[idx] = 1'b1;
            a_d[idx] = pick(w); b_d[idx] = pick(w);
            cin_d[idx] = 1'($urandom_range(1)); sub_d[idx] = 1'($urandom_range(1));
         end else begin
            inv[idx] = 1'b0;
         end
         #1;
         if (outv[idx] && outr[idx]) begin
            if (q.size() == 0) begin
               n_checks++;
               $display("FAIL rand_spurious[%0d]: got out_valid=1, want 0 (nothing outstanding)", idx);
            end else begin
               e = q.pop_front();
               chk($sformatf("rand_sum[%0d]", idx), sum_m[idx], e.s);
               chk($sformatf("rand_flags[%0d]", idx), 64'({cout_m[idx], st_m[idx]}), 64'({e.c, e.f}));
               if (chk_lat) chk($sformatf("rand_latency[%0d]", idx), 64'(cyc - e.t), 64'(dut_st[idx]));
               got++;
            end
         end
         if (outv[idx] && !outr[idx]) chk($sformatf("rand_stall_ready[%0d]", idx), 64'(inrdy[idx]), 64'd0);
         if (inv[idx] && inrdy[idx]) begin
            model(w, a_d[idx], b_d[idx], cin_d[idx], sub_d[idx], ms, mc, mf);
            q.push_back('{ms, mc, mf, cyc});
            sent++;
         end
      end
      inv[idx] = 1'b0; outr[idx] = 1'b1;
      chk($sformatf("rand_drained[%0d]", idx), 64'(got), 64'(nops));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 4'b0110};
      vt[1] = '{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 4'b1000};
      vt[2] = '{64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 4'b0010};
      vt[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 4'b1001};
      vt[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 4'b0111};
      vt[5] = '{64'h1234, 64'd1, 1'b1, 1'b0, 64'h1236, 1'b0, 4'b0000};
      vt[6] = '{64'd3, 64'd1, 1'b1, 1'b1, 64'd2, 1'b1, 4'b0010};
      vt[7] = '{64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 4'b0000};
      vt[8] = '{64'd0, 64'd0, 1'b0, 1'b1, 64'd0, 1'b1, 4'b0110};
      vt[9] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 4'b0011};

      for (int i = 0; i < NDUT; i++) begin
         inv[i] = 1'b0; outr[i] = 1'b1; cin_d[i] = 1'b0; sub_d[i] = 1'b0;
         a_d[i] = '0; b_d[i] = '0;
      end

      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_valid", 64'(outv[0]), 64'd0);
      chk("reset_sum", sum_m[0], 64'd0);
      chk("reset_cout", 64'(cout_m[0]), 64'd0);
      chk("reset_status", 64'(st_m[0]), 64'd0);
      chk("reset_in_ready", 64'(inrdy[0]), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", 64'(inrdy[0]), 64'd1);

      for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vt[i]);

      streaming_test();
      backpressure_test();
      reset_test();

      run_stream(0, 1000, 75, 100, 1'b1);
      run_stream(1, 1000, 75, 100, 1'b1);
      run_stream(2, 1000, 75, 100, 1'b1);
      run_stream(1, 300, 80, 60, 1'b0);
      run_stream(2, 300, 80, 60, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It generalises the 64-bit combinational CLA into a WIDTH-bit datapath split into BLOCK-bit slices, one slice per pipeline stage, with a valid/ready handshake and ARM-style NZCV flags. It sits in the ALU datapath and accepts one operation per cycle at full throughput.

Parameters:
WIDTH, 64, operand/result width in bits; WIDTH % BLOCK == 0.
BLOCK, 16, bits resolved per pipeline stage; BLOCK % 4 == 0, BLOCK >= 4.
STAGES, WIDTH/BLOCK, derived (localparam): pipeline depth and latency in cycles.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operation presented
in_ready  output  1  block can accept this cycle
A  input  WIDTH  operand A
B  input  WIDTH  operand B
Cin  input  1  carry-in, used only when sub=0
sub  input  1  1: A - B (A + ~B + 1); 0: A + B + Cin
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
Sum  output  WIDTH  result
Cout  output  1  carry out of bit WIDTH-1
status  output  4  {N, Z, C, V}

Behaviour:
- Reset (async, active-high): all stage valid bits, out_valid, Sum, Cout, status and all pipeline data registers clear to 0 immediately, independent of clock. in_ready = 1 while reset is low and the pipeline is not stalled.
- Transfer: input accepted when in_valid && in_ready at a rising edge; output consumed when out_valid && out_ready.
- Operand prep at accept: Beff = sub ? ~B : B; c0 = sub ? 1 : Cin.
- Stage k (0..STAGES-1) computes slice k (bits k*BLOCK .. k*BLOCK+BLOCK-1) from the carry registered by stage k-1 (stage 0 uses c0), using 4-bit generate/propagate groups with lookahead across groups inside the slice. No ripple across slices within one cycle.
- Skew registers: unprocessed upper operand slices advance with the operation; completed lower sum slices travel alongside it. Each stage holds exactly one operation's fields plus a valid bit.
- Latency: result appears at out_valid exactly STAGES rising edges after acceptance (4 for defaults). Throughput: 1 op/cycle when unstalled.
- Flags, registered with the final stage: N = Sum[WIDTH-1]; Z = (Sum == 0); C = Cout; V = (A[WIDTH-1] == Beff[WIDTH-1]) && (Sum[WIDTH-1] != A[WIDTH-1]). Sub carry uses ARM convention: C = 1 means no borrow.
- Stall: stall = out_valid && !out_ready. While stalled, every stage register holds, in_ready = 0, and no input is accepted. The stall is global. Bubbles do not collapse; this is intended.
- Bubbles: invalid stages propagate with valid = 0. out_valid is never asserted for a bubble.
- Simultaneous accept and consume in one cycle: both occur, with no loss or duplication.
- Ordering: results leave strictly in acceptance order.
- Reset mid-operation: all in-flight operations are discarded. After reset is released, out_valid stays 0 until STAGES cycles after the next accept.
- Sum/Cout/status hold their last value while out_valid = 0. They are meaningful only when out_valid = 1.

Test Plan:
- Defaults, out_ready=1. A=0xFFFF_FFFF_FFFF_FFFF, B=1, Cin=0, sub=0 -> 4 cycles later: out_valid=1, Sum=0, Cout=1, status=0b0110 (Z,C).
- Subtract: A=5, B=7, sub=1 -> Sum=0xFFFF_FFFF_FFFF_FFFE, Cout=0, status=0b1000 (N). Then A=7, B=5, sub=1 -> Sum=2, status=0b0010 (C).
- Overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> Sum=0x8000_0000_0000_0000, status=0b1001 (N,V). Then A=B=0x8000_0000_0000_0000 -> Sum=0, status=0b0111 (Z,C,V).
- Streaming: in_valid held high for 16 cycles with A=0..15, B=0, Cin=1 -> Sums 1..16 on 16 consecutive cycles, starting exactly 4 cycles after the first accept.
- Backpressure: out_ready=0 for 3 cycles mid-stream -> in_ready=0 during those cycles, Sum held stable; after release the full sequence arrives with no gaps, duplicates or reordering.
- Reset mid-stream: assert reset between clock edges with 3 ops in flight -> out_valid=0 and Sum=0 immediately. After release, no stale result appears, and a new op completes 4 cycles after its accept.
- Parameter sweep: WIDTH=32/BLOCK=8 and WIDTH=64/BLOCK=4 with 1000 random {A,B,Cin,sub} ops -> every result and flag matches the behavioural A+B model; latency equals STAGES.
